fft_iterative_engine: RTL and testbench
=======================================

// Module: fft_iterative_engine
// PURPOSE
//  Parametrised radix-2 DIT FFT/IFFT over N_SAMPLES complex fixed-point samples.
//  Reuses a single stage of N/2 butterflies for log2(N) cycles instead of unrolling every stage.
//  Supports any power-of-two N with generic bit reversal, complex input, and per-frame inverse mode.
//  Sits between the sample framer and the magnitude/classifier blocks; it is the successor of the unrolled 2/8-point FFT.
// PARAMETERS
//  BIT_WIDTH   32  sample/twiddle width, two's complement
//  DECIMAL_PT  16  fractional bits (Q(BIT_WIDTH-DECIMAL_PT).DECIMAL_PT)
//  N_SAMPLES   8   FFT size; power of two, >= 2
// PORTS
//  clk        in   1                        clock; all state updates on posedge
//  reset      in   1                        synchronous, active-high
//  recv_real  in   BIT_WIDTH x N_SAMPLES    input frame, real parts, natural order
//  recv_imag  in   BIT_WIDTH x N_SAMPLES    input frame, imaginary parts
//  recv_inv   in   1                        1 = inverse transform for this frame; sampled with the frame
//  recv_val   in   1                        input frame valid
//  recv_rdy   out  1                        engine can accept a frame
//  send_real  out  BIT_WIDTH x N_SAMPLES    result, real parts, natural order
//  send_imag  out  BIT_WIDTH x N_SAMPLES    result, imaginary parts
//  send_val   out  1                        result valid
//  send_rdy   in   1                        downstream accepts the result
// BEHAVIOUR
//  - Reset: state=IDLE, stage counter=0, data registers=0. recv_rdy=0 and send_val=0 while reset is high.
//    Reset has priority over every other event, including a mid-COMPUTE frame (discarded) and DONE+send_rdy.
//  - FSM IDLE -> COMPUTE -> DONE -> IDLE. recv_rdy=(state==IDLE); send_val=(state==DONE).
//  - IDLE: on recv_val&&recv_rdy, load reg[bitrev(i)]=recv[i] for all i (bitrev over log2(N) bits).
//    Latch recv_inv, set stage=0, go to COMPUTE.
//  - COMPUTE: each cycle applies stage s to every butterfly and writes back in place. Span h=2^s; pairs are (i, i+h)
//    for i with (i mod 2h)<h. Twiddle W=exp(-/+j*2*pi*k/N), with k=(i mod h)*(N/(2h)) and the sign + when inverse.
//    a'=a+W*b, b'=a-W*b. When s==log2(N)-1, go to DONE; otherwise s++.
//  - Arithmetic: complex multiply uses 2*BIT_WIDTH products, then an arithmetic shift right by DECIMAL_PT
//    (truncation toward -inf). Adds and subtracts wrap modulo 2^BIT_WIDTH with no saturation.
//    In inverse mode each stage output is additionally shifted right arithmetically by 1 (total 1/N scaling).
//  - Twiddles: cos/sin rounded to nearest at DECIMAL_PT, computed at elaboration; no runtime ROM writes.
//  - Latency: accept at cycle t, then COMPUTE in cycles t+1..t+log2(N); send_val=1 from cycle t+log2(N)+1.
//  - DONE: send_* hold stable while send_rdy=0, for unbounded time. When send_val&&send_rdy, go to IDLE.
//    recv_rdy rises the next cycle; there is no same-cycle accept on a send handshake (one frame in flight).
//  - recv_val in COMPUTE/DONE is ignored, and inputs other than during the IDLE handshake are don't-care.
//  - send_real/send_imag are driven directly from the register bank; values outside DONE are unspecified
//    but X-free after reset.
// STRUCTURE
//  - Package fft_pkg holds:
//    - typedef enum {IDLE,COMPUTE,DONE} fft_state_t
//    - localparam LOG2_N
//    - constant function bitrev(idx,bits)
//    - constant functions twiddle_re/twiddle_im(k,N,BIT_WIDTH,DECIMAL_PT) returning the rounded fixed-point value
//  - Sub-module fft_butterfly_comb: combinational complex butterfly (ar,ac,br,bc,wr,wc,inv_scale -> cr,cc,dr,dc).
//    N/2 instances, fed by stage-indexed muxes.
//  - Top holds the FSM, stage counter, register bank, per-stage pair/twiddle selection and write-back.
// TESTING (N=8, BIT_WIDTH=32, DECIMAL_PT=16 unless noted; 1.0=0x00010000)
//  - Impulse: real=[1.0,0,...,0], imag=0, inv=0 -> all send_real=0x00010000, send_imag=0.
//    send_val is first seen exactly 4 cycles after the accept cycle.
//  - DC: all real=1.0 -> send_real[0]=0x00080000; all other bins real=imag=0.
//  - Alternating +1.0/-1.0 -> send_real[4]=0x00080000; all other bins 0.
//    Cosine at bin 1 (real[i]=cos(2*pi*i/8)) -> bins 1 and 7 real ~=4.0 (+/-4 LSB); others ~=0.
//  - Inverse: real=[8.0,0,...,0], inv=1 -> all send_real=0x00010000, imag=0.
//    A forward-then-inverse round trip of a random frame returns the input within +/-8 LSB.
//  - Backpressure/reset: hold send_rdy=0 for 5 cycles in DONE -> outputs stable, recv_rdy=0, extra recv_val ignored.
//    Reset asserted in COMPUTE cycle 2 -> next cycle IDLE, send_val=0, and the following frame computes correctly.
//  - N_SAMPLES=2 instance: real=[3.0,1.0] -> send_real=[4.0,2.0] (0x00040000,0x00020000), send_val 2 cycles after accept.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the iterative FFT engine.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } fft_state_t;

    localparam int N_SAMPLES_DEFAULT = 8;
    localparam int LOG2_N            = $clog2(N_SAMPLES_DEFAULT);
    localparam real PI               = 3.14159265358979323846;

    // Reverse the low 'bits' bits of idx.
    function automatic int bitrev(input int idx, input int bits);
        int r;
        r = 0;
        for (int b = 0; b < bits; b++) begin
            r = (r << 1) | ((idx >> b) & 1);
        end
        return r;
    endfunction

    // Power series keep the twiddle generation to plain real arithmetic so
    // every tool can fold it at elaboration; 20 terms is exact to double
    // precision for angles up to 2*pi.
    function automatic real series_cos(input real x);
        real term;
        real sum;
        term = 1.0;
        sum  = 1.0;
        for (int n = 1; n <= 20; n++) begin
            term = -term * x * x / real'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic real series_sin(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n <= 20; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Round to nearest at dp fractional bits, clamped to the bw-bit signed range
    // (cos(0) would otherwise wrap when only one integer bit is available).
    function automatic longint to_fixed(input real v, input int bw, input int dp);
        real    scaled;
        longint q;
        longint q_max;
        scaled = v;
        for (int i = 0; i < dp; i++) begin
            scaled = scaled * 2.0;
        end
        q     = longint'(scaled);
        q_max = (longint'(1) <<< (bw - 1)) - 1;
        if (q > q_max) begin
            q = q_max;
        end
        if (q < -q_max - 1) begin
            q = -q_max - 1;
        end
        return q;
    endfunction

    // Forward twiddle W = exp(-j*2*pi*k/n); the inverse uses the conjugate.
    function automatic longint twiddle_re(input int k, input int n, input int bw, input int dp);
        return to_fixed(series_cos(2.0 * PI * real'(k) / real'(n)), bw, dp);
    endfunction

    function automatic longint twiddle_im(input int k, input int n, input int bw, input int dp);
        return to_fixed(-series_sin(2.0 * PI * real'(k) / real'(n)), bw, dp);
    endfunction

endpackage

// File: rtl/fft_butterfly_comb.sv
// Radix-2 DIT butterfly: c = a + W*b, d = a - W*b, optionally halved (inverse mode).
// Latency: combinational.
// Backpressure: none; ports: a/b/w operands (re, im), inv_scale -> c/d results (re, im).
module fft_butterfly_comb
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int DECIMAL_PT = 16
) (
    input  logic signed [BIT_WIDTH-1:0] ar,
    input  logic signed [BIT_WIDTH-1:0] ac,
    input  logic signed [BIT_WIDTH-1:0] br,
    input  logic signed [BIT_WIDTH-1:0] bc,
    input  logic signed [BIT_WIDTH-1:0] wr,
    input  logic signed [BIT_WIDTH-1:0] wc,
    input  logic                        inv_scale,
    output logic signed [BIT_WIDTH-1:0] cr,
    output logic signed [BIT_WIDTH-1:0] cc,
    output logic signed [BIT_WIDTH-1:0] dr,
    output logic signed [BIT_WIDTH-1:0] dc
);
    localparam int PW = 2 * BIT_WIDTH;

    logic signed [PW-1:0]        br_x, bc_x, wr_x, wc_x;
    logic signed [PW-1:0]        p_rr, p_cc, p_rc, p_cr;
    logic signed [PW:0]          m_re, m_im;
    logic signed [BIT_WIDTH-1:0] wb_re, wb_im;
    logic signed [BIT_WIDTH-1:0] sum_re, sum_im, dif_re, dif_im;
    logic                        unused_bits;

    assign br_x = $signed({{BIT_WIDTH{br[BIT_WIDTH-1]}}, br});
    assign bc_x = $signed({{BIT_WIDTH{bc[BIT_WIDTH-1]}}, bc});
    assign wr_x = $signed({{BIT_WIDTH{wr[BIT_WIDTH-1]}}, wr});
    assign wc_x = $signed({{BIT_WIDTH{wc[BIT_WIDTH-1]}}, wc});

    assign p_rr = br_x * wr_x;
    assign p_cc = bc_x * wc_x;
    assign p_rc = br_x * wc_x;
    assign p_cr = bc_x * wr_x;

    // One extra bit so the full-precision sum/difference cannot overflow
    // before the fixed-point shift.
    assign m_re = {p_rr[PW-1], p_rr} - {p_cc[PW-1], p_cc};
    assign m_im = {p_rc[PW-1], p_rc} + {p_cr[PW-1], p_cr};

    // Taking the field above the fraction is an arithmetic shift right
    // (floor) followed by truncation to the sample width.
    assign wb_re = m_re[DECIMAL_PT +: BIT_WIDTH];
    assign wb_im = m_im[DECIMAL_PT +: BIT_WIDTH];

    assign sum_re = ar + wb_re;
    assign sum_im = ac + wb_im;
    assign dif_re = ar - wb_re;
    assign dif_im = ac - wb_im;

    assign cr = inv_scale ? (sum_re >>> 1) : sum_re;
    assign cc = inv_scale ? (sum_im >>> 1) : sum_im;
    assign dr = inv_scale ? (dif_re >>> 1) : dif_re;
    assign dc = inv_scale ? (dif_im >>> 1) : dif_im;

    assign unused_bits = ^{m_re[DECIMAL_PT-1:0], m_re[PW:DECIMAL_PT+BIT_WIDTH],
                           m_im[DECIMAL_PT-1:0], m_im[PW:DECIMAL_PT+BIT_WIDTH]};

endmodule

// File: rtl/fft_iterative_engine.sv
// Iterative radix-2 DIT FFT/IFFT: one stage of N/2 butterflies reused log2(N) times.
// Latency: accept at t, compute t+1..t+log2(N), send_val from t+log2(N)+1; one frame in flight.
// Backpressure: result held in DONE until send_rdy; recv_rdy only in IDLE.
// Ports: clk, reset (sync, active-high); recv_real/imag/inv/val -> recv_rdy;
//        send_real/imag/val <- send_rdy. Frames are natural order, Q(BIT_WIDTH-DECIMAL_PT).DECIMAL_PT.
module fft_iterative_engine
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int DECIMAL_PT = 16,
    parameter int N_SAMPLES  = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  recv_real,
    input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  recv_imag,
    input  logic                                 recv_inv,
    input  logic                                 recv_val,
    output logic                                 recv_rdy,
    output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  send_real,
    output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  send_imag,
    output logic                                 send_val,
    input  logic                                 send_rdy
);
    localparam int               LOG_N      = $clog2(N_SAMPLES);
    localparam int               HALF       = N_SAMPLES / 2;
    localparam logic [LOG_N-1:0] LAST_STAGE = LOG_N'(LOG_N - 1);

    fft_state_t                  state, state_nxt;
    logic [LOG_N-1:0]            stage;
    logic                        inv_q;
    logic signed [BIT_WIDTH-1:0] re_q  [N_SAMPLES];
    logic signed [BIT_WIDTH-1:0] im_q  [N_SAMPLES];
    logic signed [BIT_WIDTH-1:0] tw_re [N_SAMPLES];
    logic signed [BIT_WIDTH-1:0] tw_im [N_SAMPLES];
    logic [LOG_N-1:0]            a_idx [HALF];
    logic [LOG_N-1:0]            b_idx [HALF];
    logic [LOG_N-1:0]            k_idx [HALF];
    logic signed [BIT_WIDTH-1:0] cr [HALF], cc [HALF], dr [HALF], dc [HALF];

    // Butterfly j at span 2^s: top element sits in group j>>s, offset j mod 2^s.
    function automatic int pair_top(input int j, input int s);
        return ((j >> s) << (s + 1)) + (j & ((1 << s) - 1));
    endfunction

    // k = (i mod h) * N/(2h) reduces to the group offset shifted up.
    function automatic int pair_k(input int j, input int s);
        return (j & ((1 << s) - 1)) << (LOG_N - 1 - s);
    endfunction

    // Twiddles are constants; only the first N/2 entries are ever addressed.
    for (genvar k = 0; k < N_SAMPLES; k++) begin : g_tw
        assign tw_re[k] = BIT_WIDTH'(twiddle_re(k, N_SAMPLES, BIT_WIDTH, DECIMAL_PT));
        assign tw_im[k] = BIT_WIDTH'(twiddle_im(k, N_SAMPLES, BIT_WIDTH, DECIMAL_PT));
    end

    always_comb begin
        for (int j = 0; j < HALF; j++) begin
            a_idx[j] = LOG_N'(pair_top(j, int'(stage)));
            b_idx[j] = LOG_N'(pair_top(j, int'(stage)) + (1 << stage));
            k_idx[j] = LOG_N'(pair_k(j, int'(stage)));
        end
    end

    for (genvar j = 0; j < HALF; j++) begin : g_bfly
        fft_butterfly_comb #(
            .BIT_WIDTH (BIT_WIDTH),
            .DECIMAL_PT(DECIMAL_PT)
        ) u_bfly (
            .ar       (re_q[a_idx[j]]),
            .ac       (im_q[a_idx[j]]),
            .br       (re_q[b_idx[j]]),
            .bc       (im_q[b_idx[j]]),
            .wr       (tw_re[k_idx[j]]),
            .wc       (inv_q ? -tw_im[k_idx[j]] : tw_im[k_idx[j]]),
            .inv_scale(inv_q),
            .cr       (cr[j]),
            .cc       (cc[j]),
            .dr       (dr[j]),
            .dc       (dc[j])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake outputs are masked during reset so nothing is offered or
    // accepted while reset is high, whatever state the register holds.
    always_comb begin
        state_nxt = state;
        recv_rdy  = 1'b0;
        send_val  = 1'b0;
        case (state)
            IDLE: begin
                recv_rdy = !reset;
                if (recv_val) begin
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                if (stage == LAST_STAGE) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                send_val = !reset;
                if (send_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage <= '0;
            inv_q <= 1'b0;
            for (int i = 0; i < N_SAMPLES; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (recv_val) begin
                        for (int i = 0; i < N_SAMPLES; i++) begin
                            re_q[LOG_N'(bitrev(i, LOG_N))] <= recv_real[i];
                            im_q[LOG_N'(bitrev(i, LOG_N))] <= recv_imag[i];
                        end
                        inv_q <= recv_inv;
                        stage <= '0;
                    end
                end
                COMPUTE: begin
                    // Pairs within a stage are disjoint, so in-place write-back is safe.
                    for (int j = 0; j < HALF; j++) begin
                        re_q[a_idx[j]] <= cr[j];
                        im_q[a_idx[j]] <= cc[j];
                        re_q[b_idx[j]] <= dr[j];
                        im_q[b_idx[j]] <= dc[j];
                    end
                    if (stage != LAST_STAGE) begin
                        stage <= stage + LOG_N'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < N_SAMPLES; i++) begin : g_out
        assign send_real[i] = re_q[i];
        assign send_imag[i] = im_q[i];
    end

endmodule

// File: tb/tb_fft_iterative_engine.sv
module tb_fft_iterative_engine;
    localparam int  BW  = 32;
    localparam int  N   = 8;
    localparam int  ONE = 32'h0001_0000;
    localparam real PI  = 3.14159265358979323846;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0][BW-1:0] recv_real, recv_imag, send_real, send_imag;
    logic                 recv_inv, recv_val, recv_rdy, send_val, send_rdy;

    logic [1:0][BW-1:0]   recv2_real, recv2_imag, send2_real, send2_imag;
    logic                 recv2_inv, recv2_val, recv2_rdy, send2_val, send2_rdy;

    always #5 clk = ~clk;

    fft_iterative_engine #(.BIT_WIDTH(BW), .DECIMAL_PT(16), .N_SAMPLES(N)) dut (
        .clk(clk), .reset(reset),
        .recv_real(recv_real), .recv_imag(recv_imag), .recv_inv(recv_inv),
        .recv_val(recv_val), .recv_rdy(recv_rdy),
        .send_real(send_real), .send_imag(send_imag),
        .send_val(send_val), .send_rdy(send_rdy)
    );

    fft_iterative_engine #(.BIT_WIDTH(BW), .DECIMAL_PT(16), .N_SAMPLES(2)) dut2 (
        .clk(clk), .reset(reset),
        .recv_real(recv2_real), .recv_imag(recv2_imag), .recv_inv(recv2_inv),
        .recv_val(recv2_val), .recv_rdy(recv2_rdy),
        .send_real(send2_real), .send_imag(send2_imag),
        .send_val(send2_val), .send_rdy(send2_rdy)
    );

    int checks   = 0;
    int failures = 0;
    int in_re  [N], in_im  [N];
    int out_re [N], out_im [N];
    int exp_re [N], exp_im [N];
    int orig_re[N], orig_im[N];
    int lat;

    task automatic check_val(input string tag, input longint got, input longint exp,
                             input longint tol = 0);
        longint diff;
        checks++;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // Direct DFT in real arithmetic; inverse uses the conjugate kernel and 1/N.
    task automatic model_dft(input bit inv);
        real sr, si, th, xr, xi;
        for (int k = 0; k < N; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < N; n++) begin
                th = 2.0 * PI * real'(n * k) / real'(N);
                xr = real'(in_re[n]) / 65536.0;
                xi = real'(in_im[n]) / 65536.0;
                if (inv) begin
                    sr = sr + xr * $cos(th) - xi * $sin(th);
                    si = si + xi * $cos(th) + xr * $sin(th);
                end else begin
                    sr = sr + xr * $cos(th) + xi * $sin(th);
                    si = si + xi * $cos(th) - xr * $sin(th);
                end
            end
            if (inv) begin
                sr = sr / real'(N);
                si = si / real'(N);
            end
            exp_re[k] = int'(longint'(sr * 65536.0));
            exp_im[k] = int'(longint'(si * 65536.0));
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            in_re[i] = 0;
            in_im[i] = 0;
        end
    endtask

    task automatic set_expected(input int re_all, input int im_all);
        for (int i = 0; i < N; i++) begin
            exp_re[i] = re_all;
            exp_im[i] = im_all;
        end
    endtask

    // Called at a negedge; returns at the negedge of the first DONE cycle with
    // lat = cycles from the accept cycle to the first send_val.
    task automatic run_frame(input bit inv, output int cycles);
        for (int i = 0; i < N; i++) begin
            recv_real[i] = in_re[i];
            recv_imag[i] = in_im[i];
        end
        recv_inv = inv;
        recv_val = 1'b1;
        for (int n = 0; n < 20 && !recv_rdy; n++) @(negedge clk);
        check_val("recv_rdy_wait", recv_rdy, 1);
        @(negedge clk);
        recv_val = 1'b0;
        recv_inv = 1'b0;
        cycles = 1;
        while (!send_val && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        check_val("send_val_wait", send_val, 1);
        for (int i = 0; i < N; i++) begin
            out_re[i] = $signed(send_real[i]);
            out_im[i] = $signed(send_imag[i]);
        end
    endtask

    task automatic release_frame();
        send_rdy = 1'b1;
        @(negedge clk);
        send_rdy = 1'b0;
    endtask

    task automatic compare_outputs(input string tag, input int tol);
        for (int k = 0; k < N; k++) begin
            check_val($sformatf("%s_re%0d", tag, k), out_re[k], exp_re[k], tol);
            check_val($sformatf("%s_im%0d", tag, k), out_im[k], exp_im[k], tol);
        end
    endtask

    initial begin
        reset      = 1'b1;
        recv_real  = '0;
        recv_imag  = '0;
        recv_inv   = 1'b0;
        recv_val   = 1'b0;
        send_rdy   = 1'b0;
        recv2_real = '0;
        recv2_imag = '0;
        recv2_inv  = 1'b0;
        recv2_val  = 1'b0;
        send2_rdy  = 1'b0;

        repeat (2) @(negedge clk);
        check_val("rst_recv_rdy", recv_rdy, 0);
        check_val("rst_send_val", send_val, 0);
        reset = 1'b0;
        @(negedge clk);
        check_val("idle_recv_rdy", recv_rdy, 1);
        check_val("idle_send_val", send_val, 0);
        check_val("rst_data_re0", $signed(send_real[0]), 0);
        check_val("rst_data_im7", $signed(send_imag[N-1]), 0);

        // Impulse: flat spectrum, 4-cycle latency
        clear_inputs();
        in_re[0] = ONE;
        set_expected(ONE, 0);
        run_frame(1'b0, lat);
        check_val("impulse_latency", lat, 4);
        compare_outputs("impulse", 0);
        release_frame();

        // DC
        clear_inputs();
        for (int i = 0; i < N; i++) in_re[i] = ONE;
        set_expected(0, 0);
        exp_re[0] = 8 * ONE;
        run_frame(1'b0, lat);
        compare_outputs("dc", 0);
        release_frame();

        // Alternating +1/-1 lands in bin N/2
        clear_inputs();
        for (int i = 0; i < N; i++) in_re[i] = (i % 2 == 0) ? ONE : -ONE;
        set_expected(0, 0);
        exp_re[4] = 8 * ONE;
        run_frame(1'b0, lat);
        compare_outputs("alt", 0);
        release_frame();

        // Cosine at bin 1
        clear_inputs();
        for (int i = 0; i < N; i++)
            in_re[i] = int'(longint'($cos(2.0 * PI * real'(i) / 8.0) * 65536.0));
        model_dft(1'b0);
        check_val("cos_model_bin1", exp_re[1], 4 * ONE, 4);
        run_frame(1'b0, lat);
        compare_outputs("cos", 4);
        release_frame();

        // Inverse of a scaled impulse
        clear_inputs();
        in_re[0] = 8 * ONE;
        set_expected(ONE, 0);
        run_frame(1'b1, lat);
        check_val("inv_latency", lat, 4);
        compare_outputs("inv_imp", 0);
        release_frame();

        // Random frames: forward vs model, inverse vs model and round trip
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < N; i++) begin
                in_re[i]   = int'($urandom_range(131072, 0)) - 65536;
                in_im[i]   = int'($urandom_range(131072, 0)) - 65536;
                orig_re[i] = in_re[i];
                orig_im[i] = in_im[i];
            end
            model_dft(1'b0);
            run_frame(1'b0, lat);
            compare_outputs($sformatf("rnd%0d_fwd", t), 8);
            release_frame();
            for (int i = 0; i < N; i++) begin
                in_re[i] = out_re[i];
                in_im[i] = out_im[i];
            end
            model_dft(1'b1);
            run_frame(1'b1, lat);
            compare_outputs($sformatf("rnd%0d_inv", t), 8);
            for (int i = 0; i < N; i++) begin
                check_val($sformatf("rnd%0d_trip_re%0d", t, i), out_re[i], orig_re[i], 8);
                check_val($sformatf("rnd%0d_trip_im%0d", t, i), out_im[i], orig_im[i], 8);
            end
            release_frame();
        end

        // Backpressure: hold DONE for 5 cycles while extra frames are offered
        clear_inputs();
        in_re[0] = ONE;
        run_frame(1'b0, lat);
        for (int c = 0; c < 5; c++) begin
            recv_val     = 1'b1;
            recv_real[0] = $urandom;
            recv_real[3] = $urandom;
            @(negedge clk);
            check_val($sformatf("bp%0d_send_val", c), send_val, 1);
            check_val($sformatf("bp%0d_recv_rdy", c), recv_rdy, 0);
            check_val($sformatf("bp%0d_re0", c), $signed(send_real[0]), ONE);
            check_val($sformatf("bp%0d_re5", c), $signed(send_real[5]), ONE);
            check_val($sformatf("bp%0d_im2", c), $signed(send_imag[2]), 0);
        end
        recv_val = 1'b0;
        release_frame();
        check_val("bp_after_recv_rdy", recv_rdy, 1);
        check_val("bp_after_send_val", send_val, 0);

        // Reset during the second COMPUTE cycle
        for (int i = 0; i < N; i++) begin
            recv_real[i] = $urandom;
            recv_imag[i] = $urandom;
        end
        recv_val = 1'b1;
        @(negedge clk);
        recv_val = 1'b0;
        check_val("mid_compute_send_val", send_val, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_rst_send_val", send_val, 0);
        check_val("mid_rst_recv_rdy", recv_rdy, 0);
        check_val("mid_rst_data_re0", $signed(send_real[0]), 0);
        reset = 1'b0;
        @(negedge clk);
        check_val("post_rst_recv_rdy", recv_rdy, 1);
        check_val("post_rst_send_val", send_val, 0);
        clear_inputs();
        for (int i = 0; i < N; i++) in_re[i] = ONE;
        set_expected(0, 0);
        exp_re[0] = 8 * ONE;
        run_frame(1'b0, lat);
        check_val("post_rst_latency", lat, 4);
        compare_outputs("post_rst_dc", 0);
        release_frame();

        // Two-point instance
        recv2_real[0] = 3 * ONE;
        recv2_real[1] = ONE;
        recv2_imag    = '0;
        recv2_val     = 1'b1;
        for (int n = 0; n < 20 && !recv2_rdy; n++) @(negedge clk);
        check_val("n2_recv_rdy", recv2_rdy, 1);
        @(negedge clk);
        recv2_val = 1'b0;
        lat = 1;
        while (!send2_val && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_val("n2_latency", lat, 2);
        check_val("n2_re0", $signed(send2_real[0]), 4 * ONE);
        check_val("n2_re1", $signed(send2_real[1]), 2 * ONE);
        check_val("n2_im0", $signed(send2_imag[0]), 0);
        check_val("n2_im1", $signed(send2_imag[1]), 0);
        send2_rdy = 1'b1;
        @(negedge clk);
        send2_rdy = 1'b0;
        check_val("n2_after_recv_rdy", recv2_rdy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
